// File: rtl/signal_measure_ctrl.sv
// Frequency / duty-cycle measurement of one asynchronous input over AVG_CYCLES periods.
// Define SIGNAL_MEASURE_DUTY_EN to build the duty divider; otherwise duty reads 0.
module signal_measure_ctrl #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int AVG_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = CLK_FREQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sig_in,
    output logic        busy,
    output logic        finish,
    output logic [25:0] period_out,
    output logic [7:0]  duty,
    output logic [19:0] high_time,
    output logic [19:0] low_time
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_CALC    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       AVG_LAST = 8'(AVG_CYCLES - 1);

    function automatic logic [25:0] sat_inc26(input logic [25:0] v);
        return (v == '1) ? v : v + 26'd1;
    endfunction

    function automatic logic [19:0] sat_inc20(input logic [19:0] v);
        return (v == '1) ? v : v + 20'd1;
    endfunction

    function automatic logic [7:0] clamp_duty(input logic [26:0] q);
        return (q > 27'd100) ? 8'd100 : q[7:0];
    endfunction

    logic [2:0]       state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [25:0]      acc_per_q, acc_per_d;
    logic [19:0]      acc_hi_q, acc_hi_d;
    logic [19:0]      acc_lo_q, acc_lo_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;
    logic [25:0]      per_out_q, per_out_d;
    logic [19:0]      hi_out_q, hi_out_d;
    logic [19:0]      lo_out_q, lo_out_d;
    logic [7:0]       duty_q, duty_d;

`ifdef SIGNAL_MEASURE_DUTY_EN
    logic [26:0] div_num_q, div_num_d;
    logic [25:0] div_rem_q, div_rem_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [26:0] rem_shift;
    logic [26:0] den;

    // Restoring division: the numerator shifts out MSB-first and is replaced by quotient bits.
    assign rem_shift = {div_rem_q, div_num_q[26]};
    assign den       = {1'b0, acc_per_q};
`endif

    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        acc_per_d = acc_per_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        tmo_hit   = 1'b0;
        busy_d    = busy_q;
        finish_d  = finish_q;
        per_out_d = per_out_q;
        hi_out_d  = hi_out_q;
        lo_out_d  = lo_out_q;
        duty_d    = duty_q;
`ifdef SIGNAL_MEASURE_DUTY_EN
        div_num_d = div_num_q;
        div_rem_d = div_rem_q;
        div_cnt_d = div_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (enable) begin
                    state_d   = S_ARM;
                    acc_per_d = '0;
                    acc_hi_d  = '0;
                    acc_lo_d  = '0;
                    cnt_d     = '0;
                    tmo_d     = '0;
                    busy_d    = 1'b1;
                    finish_d  = 1'b0;
                end
            end
            S_ARM: begin
                if (rise) begin
                    state_d = S_MEASURE;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_MEASURE: begin
                if (rise && cnt_q == AVG_LAST) begin
                    state_d = S_CALC;
`ifdef SIGNAL_MEASURE_DUTY_EN
                    div_num_d = 27'(acc_hi_q) * 27'd100;
                    div_rem_d = '0;
                    div_cnt_d = 5'd27;
`endif
                end else begin
                    if (rise) begin
                        cnt_d = cnt_q + 8'd1;
                        tmo_d = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_hit = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    // s3 is the edge-detect register, so high/low split lines up with rise.
                    acc_per_d = sat_inc26(acc_per_q);
                    if (s3_q) acc_hi_d = sat_inc20(acc_hi_q);
                    else      acc_lo_d = sat_inc20(acc_lo_q);
                end
            end
            S_CALC: begin
`ifdef SIGNAL_MEASURE_DUTY_EN
                if (div_cnt_q != 5'd0) begin
                    div_cnt_d = div_cnt_q - 5'd1;
                    if (rem_shift >= den) begin
                        div_rem_d = 26'(rem_shift - den);
                        div_num_d = {div_num_q[25:0], 1'b1};
                    end else begin
                        div_rem_d = rem_shift[25:0];
                        div_num_d = {div_num_q[25:0], 1'b0};
                    end
                end else begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    finish_d  = 1'b1;
                    per_out_d = acc_per_q;
                    hi_out_d  = acc_hi_q;
                    lo_out_d  = acc_lo_q;
                    duty_d    = (acc_per_q == '0) ? 8'd0 : clamp_duty(div_num_q);
                end
`else
                state_d   = S_DONE;
                busy_d    = 1'b0;
                finish_d  = 1'b1;
                per_out_d = acc_per_q;
                hi_out_d  = acc_hi_q;
                lo_out_d  = acc_lo_q;
                duty_d    = 8'd0;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            finish_d  = 1'b1;
            per_out_d = '0;
            hi_out_d  = '0;
            lo_out_d  = '0;
            duty_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
            per_out_q <= '0;
            hi_out_q  <= '0;
            lo_out_q  <= '0;
            duty_q    <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            finish_q  <= finish_d;
            per_out_q <= per_out_d;
            hi_out_q  <= hi_out_d;
            lo_out_q  <= lo_out_d;
            duty_q    <= duty_d;
        end
    end

    // Datapath registers are always cleared on start, so they carry no reset.
    always_ff @(posedge clk) begin
        acc_per_q <= acc_per_d;
        acc_hi_q  <= acc_hi_d;
        acc_lo_q  <= acc_lo_d;
`ifdef SIGNAL_MEASURE_DUTY_EN
        div_num_q <= div_num_d;
        div_rem_q <= div_rem_d;
        div_cnt_q <= div_cnt_d;
`endif
    end

    assign busy       = busy_q;
    assign finish     = finish_q;
    assign period_out = per_out_q;
    assign high_time  = hi_out_q;
    assign low_time   = lo_out_q;
    assign duty       = duty_q;

endmodule

// File: tb/tb_signal_measure_ctrl.sv
// Directed bench for signal_measure_ctrl: 50 MHz clock, AVG_CYCLES=8, TIMEOUT_CYCLES=1000.
`timescale 1ns/1ps
module tb_signal_measure_ctrl;

`ifdef SIGNAL_MEASURE_DUTY_EN
    localparam int DUTY_A   = 40;
    localparam int DUTY_B   = 55;
    localparam int DUTY_TOL = 1;
`else
    localparam int DUTY_A   = 0;
    localparam int DUTY_B   = 0;
    localparam int DUTY_TOL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sig_in;
    logic        busy;
    logic        finish;
    logic [25:0] period_out;
    logic [7:0]  duty;
    logic [19:0] high_time;
    logic [19:0] low_time;

    int n_checks = 0;
    int n_fail   = 0;
    int gen_hi   = 800;
    int gen_lo   = 1200;
    bit gen_en   = 1'b0;
    int cyc;
    bit bok;

    signal_measure_ctrl #(
        .CLK_FREQ      (50_000_000),
        .AVG_CYCLES    (8),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .busy      (busy),
        .finish    (finish),
        .period_out(period_out),
        .duty      (duty),
        .high_time (high_time),
        .low_time  (low_time)
    );

    always #10 clk = ~clk;

    // Input edges sit at 7 ns mod 20 ns, clear of the 10 ns mod 20 ns clock edges.
    initial begin
        sig_in = 1'b0;
        #7;
        forever begin
            if (gen_en) begin
                sig_in = 1'b1;
                #(gen_hi);
                sig_in = 1'b0;
                #(gen_lo);
            end else begin
                sig_in = 1'b0;
                #20;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected $finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic pulse_en(input int n);
        enable = 1'b1;
        repeat (n) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_finish(input int max_cyc, output int c, output bit ok);
        c  = 0;
        ok = 1'b1;
        while (!finish && c < max_cyc) begin
            @(negedge clk);
            c++;
            if (!finish && !busy) ok = 1'b0;
        end
    endtask

    task automatic check_result(input string pfx, input int p, input int h, input int l, input int d);
        chk({pfx, "_finish"}, int'(finish), 1, 0);
        chk({pfx, "_busy_hold"}, int'(bok), 1, 0);
        chk({pfx, "_busy_end"}, int'(busy), 0, 0);
        chk({pfx, "_period"}, int'(period_out), p, 1);
        chk({pfx, "_high"}, int'(high_time), h, 1);
        chk({pfx, "_low"}, int'(low_time), l, 1);
        chk({pfx, "_duty"}, int'(duty), d, DUTY_TOL);
        chk({pfx, "_ident"}, int'(period_out), int'(high_time) + int'(low_time), 0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (7) @(negedge clk);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_finish", int'(finish), 0, 0);
        chk("rst_period", int'(period_out), 0, 0);
        chk("rst_high", int'(high_time), 0, 0);
        chk("rst_low", int'(low_time), 0, 0);
        chk("rst_duty", int'(duty), 0, 0);
        enable = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_start", int'(busy), 0, 0);

        // 500 kHz, 40 %: 100 clk period, 40 high.
        gen_en = 1'b1;
        repeat (50) @(negedge clk);
        pulse_en(2);
        chk("m1_busy_start", int'(busy), 1, 0);
        chk("m1_finish_start", int'(finish), 0, 0);
        wait_finish(2000, cyc, bok);
        check_result("m1", 800, 320, 480, DUTY_A);

        // 833 kHz, 55 %: 60 clk period, 33 high.
        gen_hi = 660;
        gen_lo = 540;
        repeat (1000) @(negedge clk);
        pulse_en(1);
        chk("m2_finish_clr", int'(finish), 0, 0);
        chk("m2_busy_start", int'(busy), 1, 0);
        wait_finish(2000, cyc, bok);
        check_result("m2", 480, 264, 216, DUTY_B);

        // Reset in the middle of a measurement.
        gen_hi = 800;
        gen_lo = 1200;
        repeat (20) @(negedge clk);
        pulse_en(1);
        repeat (300) @(negedge clk);
        chk("mr_busy_pre", int'(busy), 1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_busy", int'(busy), 0, 0);
        chk("mr_finish", int'(finish), 0, 0);
        chk("mr_period", int'(period_out), 0, 0);
        chk("mr_high", int'(high_time), 0, 0);
        chk("mr_low", int'(low_time), 0, 0);
        chk("mr_duty", int'(duty), 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_en(1);
        wait_finish(2000, cyc, bok);
        check_result("m3", 800, 320, 480, DUTY_A);

        // Constant-low input: timeout after 1000 cycles with zero results.
        gen_en = 1'b0;
        repeat (200) @(negedge clk);
        pulse_en(1);
        wait_finish(1100, cyc, bok);
        chk("to_finish", int'(finish), 1, 0);
        chk("to_cycles", cyc, 1000, 1);
        chk("to_busy", int'(busy), 0, 0);
        chk("to_period", int'(period_out), 0, 0);
        chk("to_high", int'(high_time), 0, 0);
        chk("to_low", int'(low_time), 0, 0);
        chk("to_duty", int'(duty), 0, 0);

        // Second enable while busy must be ignored.
        gen_en = 1'b1;
        repeat (50) @(negedge clk);
        pulse_en(1);
        repeat (200) @(negedge clk);
        chk("mb_busy_mid", int'(busy), 1, 0);
        pulse_en(3);
        chk("mb_busy_after", int'(busy), 1, 0);
        wait_finish(2000, cyc, bok);
        check_result("m4", 800, 320, 480, DUTY_A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_measure_ctrl.md
Name: signal_measure_ctrl

Overview:
- Frequency and duty-cycle measurement controller for one digital input, `sig_in`, which is asynchronous to `clk`.
- On an `enable` pulse it synchronises `sig_in` and waits for a rising edge.
- It then counts clk cycles over AVG_CYCLES consecutive input periods and reports total period, high time, low time and duty percent.
- Sits between the input pin conditioning and the register/host interface of the debugger.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz. Sets the default timeout.
- AVG_CYCLES, 8, number of consecutive input periods accumulated. Legal range 1..255.
- TIMEOUT_CYCLES, CLK_FREQ, clk cycles allowed with no rising edge before the measurement aborts.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, start request; sampled high for one or more cycles while idle.
- sig_in, input, 1, asynchronous signal under test.
- busy, output, 1, high from the accepted start until finish.
- finish, output, 1, result-valid level.
- period_out, output, 26, summed period over AVG_CYCLES periods, in clk cycles.
- duty, output, 8, high_time*100/period_out, integer percent 0..100.
- high_time, output, 20, summed high clk cycles.
- low_time, output, 20, summed low clk cycles.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. On rst, every output is 0, the FSM goes to IDLE and the synchroniser is cleared.
- Input path: two-flop synchroniser on `sig_in`, plus a third register for edge detect. rise = s2 & ~s3.
- FSM states: IDLE, ARM, MEASURE, CALC, DONE.
- IDLE:
  - enable=1 → clear the accumulators and the period counter, set busy=1, clear finish, go to ARM.
  - The result outputs keep their previous values until the new result loads.
- ARM: wait for the first rise, then go to MEASURE.
- MEASURE:
  - Every cycle, increment the period accumulator.
  - Increment the high accumulator if s3=1, else the low accumulator. Using s3 keeps the counting aligned with the edge-detect register.
  - Each rise increments the period count. When the count reaches AVG_CYCLES, go to CALC; the cycle of that rise is not counted.
- Result identity: period_out == high_time + low_time exactly.
- Accumulator saturation: the period accumulator saturates at 2^26-1 and the high/low accumulators at 2^20-1; none of them wraps. If any accumulator saturates, the identity need not hold.
- CALC:
  - Latch the three sums to the outputs.
  - Compute duty = (high*100)/period with a sequential restoring divider, at most 32 cycles. Numerator is 27 bits.
  - Clamp duty to 100.
  - If period = 0, duty = 0.
- DONE:
  - finish=1 and busy=0. Hold the outputs and stay in DONE.
  - enable=1 in DONE starts a new measurement exactly as from IDLE, clearing finish.
- Timeout: in ARM or MEASURE, if TIMEOUT_CYCLES elapse without a rise, go to DONE with all four results 0 and finish=1.
- Timeout counter: reloads on every rise.
- enable while busy=1: ignored.
- rst mid-measurement: immediate abort to IDLE, outputs 0.
- Latency: finish rises ≤ 36 clk after the closing synchronised rise. The rise itself lags `sig_in` by 2–3 clk.
- Sampling accuracy: the result is accurate to ±1 clk per measured edge.

Optional Feature:
- Macro: SIGNAL_MEASURE_DUTY_EN.
- Defined: the divider is built; CALC performs the division; duty is as above.
- Undefined:
  - No divider is built and duty is tied to 0.
  - CALC lasts one cycle, so finish rises exactly 2 clk after the closing rise.
  - All other outputs are identical.

Test Plan:
- Reset: hold rst=1 for 10 cycles → busy=0, finish=0, all outputs 0. enable during reset → no start.
- Pulse enable for 2 cycles with sig_in at 500 kHz, 40% (2000 ns period, 50 MHz clk) → busy=1 until finish. Then:
  - period_out=800±1, high_time=320±1, low_time=480±1.
  - duty=40 with the macro, 0 without.
  - period_out==high_time+low_time.
- After a result, switch to 833 kHz, 55% (1200 ns) and wait 20 µs. Pulse enable → finish cleared on start, then period_out=480±1, high_time=264±1, low_time=216±1, duty=55.
- Hold sig_in constant 0 and pulse enable → finish after TIMEOUT_CYCLES (set to 1000 in the bench) with all results 0 and busy=0.
- Assert rst during MEASURE → next cycle in IDLE with outputs 0. A fresh enable then measures correctly.
- Pulse enable again while busy → ignored. The result matches a single measurement, and busy never drops early.
